// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: ticked button sampler, dot/dash classifier,
// letter assembler and one-entry valid/ready output register.
// Optional build macro: MORSE_DEBOUNCE_EN (2-flop sync + 2-tick debounce).
module morse_letter_decoder #(
  parameter int TICK_DIV    = 4,
  parameter int DOT_MAX     = 2,
  parameter int LETTER_GAP  = 4,
  parameter int MAX_SYMBOLS = 5,
  parameter int CNT_W       = 8,
  localparam int LEN_W      = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   EN,
  input  logic                   BTN_IN,
  input  logic                   OUT_READY,
  output logic                   OUT_VALID,
  output logic [MAX_SYMBOLS-1:0] OUT_CODE,
  output logic [LEN_W-1:0]       OUT_LEN,
  output logic                   OUT_OVF,
  output logic                   DROP,
  output logic                   BLINK_LED,
  output logic [LEN_W-1:0]       CUR_LEN
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(LETTER_GAP);
  localparam logic [LEN_W-1:0] SYM_LIM  = LEN_W'(MAX_SYMBOLS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ------------------------------------------------------------
  // Tick divider
  // ------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic             tick_en;

  assign tick    = (div_q == DIV_LAST);
  assign tick_en = tick & EN;

  // Divider next count; holds while disabled so a tick resumes in place.
  always_comb begin
    div_d = div_q;
    if (EN) begin
      if (tick) div_d = '0;
      else      div_d = div_q + 1'b1;
    end
  end

  // Divider register.
  always_ff @(posedge CLK) begin
    if (RST) div_q <= '0;
    else     div_q <= div_d;
  end

  // ------------------------------------------------------------
  // Button sample path
  // ------------------------------------------------------------
  logic s;

`ifdef MORSE_DEBOUNCE_EN
  logic sy1_q, sy2_q;
  logic prev_q, prev_d;
  logic stab_q, stab_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sy1_q <= 1'b0;
      sy2_q <= 1'b0;
    end else begin
      sy1_q <= BTN_IN;
      sy2_q <= sy1_q;
    end
  end

  // Accept a new level only after two equal ticked samples.
  always_comb begin
    prev_d = prev_q;
    stab_d = stab_q;
    s      = stab_q;
    if (tick_en) begin
      prev_d = sy2_q;
      if (sy2_q == prev_q) begin
        s      = sy2_q;
        stab_d = sy2_q;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= 1'b0;
      stab_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      stab_q <= stab_d;
    end
  end
`else
  assign s = BTN_IN;
`endif

  // ------------------------------------------------------------
  // Letter assembly FSM
  // ------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       press_q, press_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [MAX_SYMBOLS-1:0] code_q, code_d;
  logic                   ovf_q, ovf_d;
  logic                   done;

  logic [CNT_W-1:0]       press_inc;
  logic [CNT_W-1:0]       gap_inc;
  logic                   is_dash;
  logic [MAX_SYMBOLS-1:0] sym_vec;

  assign press_inc = (&press_q) ? press_q : press_q + 1'b1;
  assign gap_inc   = (&gap_q) ? gap_q : gap_q + 1'b1;
  assign is_dash   = (press_q > DOT_LIM);
  assign sym_vec   = MAX_SYMBOLS'(is_dash) << len_q;

  // Next-state logic; all actions are gated by the enabled tick.
  always_comb begin
    state_d = state_q;
    press_d = press_q;
    gap_d   = gap_q;
    len_d   = len_q;
    code_d  = code_q;
    ovf_d   = ovf_q;
    done    = 1'b0;
    if (tick_en) begin
      unique case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS;
            press_d = CNT_ONE;
          end
        end
        PRESS: begin
          if (s) begin
            press_d = press_inc;
          end else begin
            if (len_q < SYM_LIM) begin
              code_d = code_q | sym_vec;
              len_d  = len_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
            state_d = GAP;
            gap_d   = CNT_ONE;
          end
        end
        GAP: begin
          if (s) begin
            state_d = PRESS;
            press_d = CNT_ONE;
          end else begin
            gap_d = gap_inc;
            if (gap_inc >= GAP_LIM) begin
              done    = 1'b1;
              state_d = IDLE;
              press_d = '0;
              gap_d   = '0;
              len_d   = '0;
              code_d  = '0;
              ovf_d   = 1'b0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          press_d = '0;
          gap_d   = '0;
          len_d   = '0;
          code_d  = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // Assembly state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      press_q <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      press_q <= press_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  // ------------------------------------------------------------
  // Output register (one entry, valid/ready)
  // ------------------------------------------------------------
  logic                   ov_q, ov_d;
  logic [MAX_SYMBOLS-1:0] oc_q, oc_d;
  logic [LEN_W-1:0]       ol_q, ol_d;
  logic                   oo_q, oo_d;
  logic                   drop_q, drop_d;
  logic                   xfer;
  logic                   load;

  assign xfer = ov_q & OUT_READY;
  assign load = done & (~ov_q | OUT_READY);

  // Load a finished letter when there is room, else flag a drop.
  always_comb begin
    ov_d   = ov_q;
    oc_d   = oc_q;
    ol_d   = ol_q;
    oo_d   = oo_q;
    drop_d = done & ~load;
    if (load) begin
      ov_d = 1'b1;
      oc_d = code_q;
      ol_d = len_q;
      oo_d = ovf_q;
    end else if (xfer) begin
      ov_d = 1'b0;
      oc_d = '0;
      ol_d = '0;
      oo_d = 1'b0;
    end
  end

  // Output register state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ov_q   <= 1'b0;
      oc_q   <= '0;
      ol_q   <= '0;
      oo_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      ov_q   <= ov_d;
      oc_q   <= oc_d;
      ol_q   <= ol_d;
      oo_q   <= oo_d;
      drop_q <= drop_d;
    end
  end

  assign OUT_VALID = ov_q;
  assign OUT_CODE  = oc_q;
  assign OUT_LEN   = ol_q;
  assign OUT_OVF   = oo_q;
  assign DROP      = drop_q;
  assign BLINK_LED = tick_en;
  assign CUR_LEN   = len_q;

endmodule
